// File: rtl/byte_permute_pipe.sv
// byte_permute_pipe: streaming byte swap/reverse/rotate unit.
// A combinational permutation feeds a registered output stage with a
// one-entry skid buffer, plus a saturating count of output transfers.
//
// Handshake: a word moves on an edge where valid && ready are both high.
// The producer holds data/mode stable while valid && !ready. in_ready_o
// depends only on registered state (skid empty), never on out_ready_i.
// out_data_o is held stable while out_valid_o && !out_ready_i.
module byte_permute_pipe #(
    parameter int BYTES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [8*BYTES-1:0] in_data_i,
    input  logic [1:0]         in_mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [8*BYTES-1:0] out_data_o,
    input  logic               cnt_clr_i,
    output logic [CNT_W-1:0]   xfer_count_o
);

    localparam int W = 8 * BYTES;

    logic [W-1:0]     perm_w;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [W-1:0]     skid_data_q,  skid_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;
    logic out_free;

    // Each output byte picks its source byte from the unmodified input word,
    // so no byte ever observes a partially permuted value.
    genvar k;
    generate
        for (k = 0; k < BYTES; k++) begin : g_byte
            localparam int J_SWAP = k ^ 1;
            localparam int J_REV  = BYTES - 1 - k;
            localparam int J_ROT  = (k + BYTES - 1) % BYTES;
            assign perm_w[8*k +: 8] =
                (in_mode_i == 2'b00) ? in_data_i[8*k      +: 8] :
                (in_mode_i == 2'b01) ? in_data_i[8*J_SWAP +: 8] :
                (in_mode_i == 2'b10) ? in_data_i[8*J_REV  +: 8] :
                                       in_data_i[8*J_ROT  +: 8];
        end
    endgenerate

    assign in_ready_o   = !skid_valid_q;
    assign in_fire      = in_valid_i && in_ready_o;
    assign out_fire     = out_valid_q && out_ready_i;
    assign out_free     = !out_valid_q || out_ready_i;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign xfer_count_o = cnt_q;

    // Next state of output and skid registers; the skid drains before new
    // input is taken, which keeps words in acceptance order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = perm_w;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm_w;
        end
    end

    // Transfer counter: clear wins over increment, increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any stored words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_byte_permute_pipe.sv
// Bench for byte_permute_pipe (BYTES=4, CNT_W=4): vector table, hand
// sequences for backpressure/reset/counter, then random traffic against
// a queue-based reference model.
module tb_byte_permute_pipe;

    localparam int BYTES = 4;
    localparam int CNT_W = 4;
    localparam int W     = 8 * BYTES;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             cnt_clr;
    logic [CNT_W-1:0] xfer_count;

    byte_permute_pipe #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_mode_i    (in_mode),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .cnt_clr_i    (cnt_clr),
        .xfer_count_o (xfer_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           model_cnt;
    int           n_vec;
    int           n_err;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   mode;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    // reference permutation from the byte-mapping rules
    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] w, input logic [1:0] m);
        logic [7:0] b[BYTES];
        logic [7:0] o[BYTES];
        logic [W-1:0] r;
        for (int k = 0; k < BYTES; k++) b[k] = w[8*k +: 8];
        for (int k = 0; k < BYTES; k++) begin
            case (m)
                2'b00: o[k] = b[k];
                2'b01: o[k] = (k % 2 == 0) ? b[k+1] : b[k-1];
                2'b10: o[k] = b[BYTES-1-k];
                default: o[k] = b[(k + BYTES - 1) % BYTES];
            endcase
        end
        r = '0;
        for (int k = 0; k < BYTES; k++) r[8*k +: 8] = o[k];
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare all DUT outputs with the model
    task automatic check_model();
        check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
        check("in_ready", W'(in_ready), W'(exp_q.size() < 2));
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        check("xfer_count", W'(xfer_count), W'(model_cnt));
    endtask

    // driver: apply one cycle of inputs, advance the model, check outputs
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [1:0] m,
                         input logic ordy, input logic clr);
        logic in_fire, out_fire;
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        cnt_clr   = clr;
        in_fire   = iv && (exp_q.size() < 2);
        out_fire  = ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) exp_q.push_back(ref_perm(d, m));
        if (clr) model_cnt = 0;
        else if (out_fire && model_cnt < (1 << CNT_W) - 1) model_cnt++;
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_cnt = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 2'b00;
        out_ready = 1'b0;
        cnt_clr = 1'b0;

        vecs[0] = '{32'h11223344, 2'b00, 32'h11223344};
        vecs[1] = '{32'h11223344, 2'b01, 32'h22114433};
        vecs[2] = '{32'h11223344, 2'b10, 32'h44332211};
        vecs[3] = '{32'h11223344, 2'b11, 32'h22334411};
        vecs[4] = '{32'hAABBCCDD, 2'b01, 32'hBBAADDCC};
        vecs[5] = '{32'hAABBCCDD, 2'b11, 32'hBBCCDDAA};
        vecs[6] = '{32'hAABBCCDD, 2'b00, 32'hAABBCCDD};

        // reset state
        #12;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_data", out_data, '0);
        check("rst_xfer", W'(xfer_count), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table: each mode, one word then a drain cycle
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, vecs[i].data, vecs[i].mode, 1'b1, 1'b0);
            check("table_data", out_data, vecs[i].exp);
            check("table_valid", W'(out_valid), W'(1));
            idle(1);
        end

        // mixed modes back to back
        for (int i = 4; i < 7; i++) begin
            cycle(1'b1, vecs[i].data, vecs[i].mode, 1'b1, 1'b0);
            check("mixed_data", out_data, vecs[i].exp);
        end
        idle(1);

        // stream of 8 reversed words
        cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 2'b10, 1'b1, 1'b0);
            check("stream_data", out_data, W'(i) << 24);
        end
        idle(1);
        check("stream_count", W'(xfer_count), W'(8));

        // backpressure: A, B absorbed, C held off until release
        cycle(1'b1, 32'hA0A1A2A3, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'hB0B1B2B3, 2'b00, 1'b0, 1'b0);
        check("bp_in_ready_low", W'(in_ready), '0);
        cycle(1'b1, 32'hC0C1C2C3, 2'b00, 1'b0, 1'b0);
        check("bp_hold_data", out_data, 32'hA0A1A2A3);
        cycle(1'b1, 32'hC0C1C2C3, 2'b00, 1'b1, 1'b0);
        check("bp_skid_out", out_data, 32'hB0B1B2B3);
        cycle(1'b1, 32'hC0C1C2C3, 2'b00, 1'b1, 1'b0);
        check("bp_c_out", out_data, 32'hC0C1C2C3);
        idle(2);

        // asynchronous reset with both registers full
        cycle(1'b1, 32'h01020304, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h05060708, 2'b00, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = 0;
        check("arst_out_valid", W'(out_valid), '0);
        check("arst_in_ready", W'(in_ready), W'(1));
        check("arst_xfer", W'(xfer_count), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // counter saturation and clear-with-handshake
        for (int i = 0; i < 17; i++) cycle(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        idle(1);
        check("sat_count", W'(xfer_count), W'(15));
        cycle(1'b1, 32'h12345678, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);
        check("clr_priority", W'(xfer_count), '0);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
